// File: rtl/aom_protect_ctrl.sv
// AOM overload protection supervisor: debounces the overload error flags, latches a
// laser-off trip and sequences recovery through host clear, cooldown and re-arm.
module aom_protect_ctrl #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             protect_en_i,
    input  logic             aom_continuous_trig_err_i,
    input  logic             aom_integral_trig_err_i,
    input  logic             fault_clr_i,
    input  logic [31:0]      cooldown_len_i,
    output logic             laser_force_off_o,
    output logic             trip_pulse_o,
    output logic [1:0]       fault_cause_o,
    output logic [CNT_W-1:0] trip_cnt_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam int unsigned     DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [31:0]      cool_cnt_q, cool_cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] trip_cnt_q, trip_cnt_d;
    logic             pulse_q, pulse_d;
    logic             force_off_q, force_off_d;
    logic             err_any;
    logic             monitoring;
    logic             trip;

    assign err_any    = aom_continuous_trig_err_i | aom_integral_trig_err_i;
    assign monitoring = (state_q == ST_ARMED) || (state_q == ST_COOLDOWN);
    // Trip fires on the DEBOUNCE-th consecutive high cycle, so the count never exceeds DB_LAST.
    assign trip       = monitoring && err_any && (db_cnt_q == DB_LAST);

    always_comb begin
        db_cnt_d = '0;
        if (monitoring && err_any && !trip) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        cause_d    = cause_q;
        trip_cnt_d = trip_cnt_q;
        pulse_d    = 1'b0;

        case (state_q)
            ST_DISABLED: begin
                if (protect_en_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!protect_en_i) begin
                    state_d = ST_DISABLED;
                end
            end
            ST_TRIPPED: begin
                // A clear while an error is still present is dropped, not deferred.
                if (fault_clr_i && !err_any) begin
                    state_d    = ST_COOLDOWN;
                    cool_cnt_d = cooldown_len_i;
                    cause_d    = 2'b00;
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt_q == 32'd0) begin
                    state_d = protect_en_i ? ST_ARMED : ST_DISABLED;
                end else begin
                    cool_cnt_d = cool_cnt_q - 32'd1;
                end
            end
            default: state_d = ST_DISABLED;
        endcase

        // Trip overrides any transition chosen above, including a disable in ARMED.
        if (trip) begin
            state_d = ST_TRIPPED;
            cause_d = {aom_integral_trig_err_i, aom_continuous_trig_err_i};
            pulse_d = 1'b1;
            if (trip_cnt_q != {CNT_W{1'b1}}) begin
                trip_cnt_d = trip_cnt_q + CNT_W'(1);
            end
        end

        force_off_d = (state_d == ST_TRIPPED) || (state_d == ST_COOLDOWN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_DISABLED;
            db_cnt_q    <= '0;
            cool_cnt_q  <= '0;
            cause_q     <= 2'b00;
            trip_cnt_q  <= '0;
            pulse_q     <= 1'b0;
            force_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            cause_q     <= cause_d;
            trip_cnt_q  <= trip_cnt_d;
            pulse_q     <= pulse_d;
            force_off_q <= force_off_d;
        end
    end

    assign laser_force_off_o = force_off_q;
    assign trip_pulse_o      = pulse_q;
    assign fault_cause_o     = cause_q;
    assign trip_cnt_o        = trip_cnt_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_aom_protect_ctrl.sv
// Bench for aom_protect_ctrl: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural model of the protection rules.
module tb_aom_protect_ctrl;

    localparam int DEBOUNCE = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             ce;
    logic             ie;
    logic             clr;
    logic [31:0]      len;
    logic             off_o;
    logic             pulse_o;
    logic [1:0]       cause_o;
    logic [CNT_W-1:0] cnt_o;
    logic [1:0]       state_o;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    // Model: state names 0 disabled, 1 armed, 2 tripped, 3 cooldown.
    int    m_state = 0;
    int    m_run   = 0;
    int    m_cause = 0;
    int    m_cnt   = 0;
    int    m_pulse = 0;
    int    m_off   = 0;
    longint m_cool = 0;

    aom_protect_ctrl #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
        .clk_i                     (clk),
        .rst_n_i                   (rst_n),
        .protect_en_i              (en),
        .aom_continuous_trig_err_i (ce),
        .aom_integral_trig_err_i   (ie),
        .fault_clr_i               (clr),
        .cooldown_len_i            (len),
        .laser_force_off_o         (off_o),
        .trip_pulse_o              (pulse_o),
        .fault_cause_o             (cause_o),
        .trip_cnt_o                (cnt_o),
        .state_o                   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_run = 0; m_cause = 0; m_cnt = 0;
            m_pulse = 0; m_off = 0; m_cool = 0;
        end else begin
            bit err;
            bit trip;
            err = ce | ie;
            if ((m_state == 1 || m_state == 3) && err) m_run = m_run + 1;
            else m_run = 0;
            trip = (m_run >= DEBOUNCE);
            m_pulse = 0;
            if (trip) begin
                m_state = 2;
                m_cause = (ie ? 2 : 0) + (ce ? 1 : 0);
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                m_pulse = 1;
                m_run   = 0;
            end else begin
                case (m_state)
                    0: if (en) m_state = 1;
                    1: if (!en) m_state = 0;
                    2: if (clr && !err) begin
                        m_state = 3;
                        m_cool  = longint'(len);
                        m_cause = 0;
                    end
                    default: begin
                        if (m_cool == 0) m_state = en ? 1 : 0;
                        else m_cool = m_cool - 1;
                    end
                endcase
            end
            m_off = (m_state == 2 || m_state == 3) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", 32'(state_o), m_state);
            check("force_off", 32'(off_o), m_off);
            check("trip_pulse", 32'(pulse_o), m_pulse);
            check("fault_cause", 32'(cause_o), m_cause);
            check("trip_cnt", 32'(cnt_o), m_cnt);
        end
    end

    initial begin
        int pat [7] = '{1, 1, 1, 0, 1, 1, 1};
        int dwell;
        bit hot;

        rst_n = 1'b0; en = 1'b0; ce = 1'b0; ie = 1'b0; clr = 1'b0; len = 32'd0;
        repeat (2) tick();
        cmp_en = 1;
        check("rst_state", 32'(state_o), 0);
        check("rst_off", 32'(off_o), 0);
        check("rst_cnt", 32'(cnt_o), 0);
        check("rst_cause", 32'(cause_o), 0);
        check("rst_pulse", 32'(pulse_o), 0);
        rst_n = 1'b1;

        // Continuous error for DEBOUNCE cycles trips on the last of them.
        en = 1'b1; tick();
        check("t1_armed", 32'(state_o), 1);
        ce = 1'b1; repeat (3) tick();
        check("t1_off_before", 32'(off_o), 0);
        tick();
        check("t1_off", 32'(off_o), 1);
        check("t1_pulse", 32'(pulse_o), 1);
        check("t1_cause", 32'(cause_o), 1);
        check("t1_cnt", 32'(cnt_o), 1);
        ce = 1'b0; tick();
        check("t1_pulse_done", 32'(pulse_o), 0);
        check("t1_held", 32'(state_o), 2);

        // Clear ignored while error present; accepted clear gives 11 cooldown cycles.
        ce = 1'b1; clr = 1'b1; tick();
        clr = 1'b0;
        check("t3_clr_ignored", 32'(state_o), 2);
        check("t3_cause_kept", 32'(cause_o), 1);
        ce = 1'b0; tick();
        clr = 1'b1; len = 32'd10; tick();
        clr = 1'b0;
        check("t3_cooldown", 32'(state_o), 3);
        check("t3_cause_clr", 32'(cause_o), 0);
        dwell = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (state_o == 2'd3) dwell++;
            else break;
        end
        check("t3_dwell", dwell, 11);
        check("t3_rearmed", 32'(state_o), 1);
        check("t3_off_low", 32'(off_o), 0);

        // Interrupted integral error does not trip; an unbroken run does.
        for (int i = 0; i < 7; i++) begin
            ie = pat[i][0]; tick();
        end
        ie = 1'b0; tick();
        check("t2_no_trip", 32'(state_o), 1);
        ie = 1'b1; repeat (4) tick();
        check("t2_trip", 32'(state_o), 2);
        check("t2_cause", 32'(cause_o), 2);
        check("t2_cnt", 32'(cnt_o), 2);
        ie = 1'b0; tick();
        clr = 1'b1; len = 32'd0; tick();
        clr = 1'b0;
        check("t2_cool0", 32'(state_o), 3);
        tick();
        check("t2_cool0_done", 32'(state_o), 1);

        // Simultaneous errors: both cause bits, one count.
        ce = 1'b1; ie = 1'b1; repeat (4) tick();
        check("t4_cause", 32'(cause_o), 3);
        check("t4_cnt", 32'(cnt_o), 3);
        ce = 1'b0; ie = 1'b0; tick();
        clr = 1'b1; len = 32'd20; tick();
        clr = 1'b0;
        check("t4_cooldown", 32'(state_o), 3);

        // Re-trip from cooldown; disable cannot leave TRIPPED; cooldown ends in DISABLED.
        ce = 1'b1; repeat (4) tick();
        check("t5_retrip", 32'(state_o), 2);
        check("t5_cnt", 32'(cnt_o), 4);
        check("t5_pulse", 32'(pulse_o), 1);
        ce = 1'b0; en = 1'b0; repeat (2) tick();
        check("t5_stay_tripped", 32'(state_o), 2);
        clr = 1'b1; len = 32'd3; tick();
        clr = 1'b0;
        check("t5_cooldown", 32'(state_o), 3);
        repeat (4) tick();
        check("t5_disabled", 32'(state_o), 0);
        check("t5_off_low", 32'(off_o), 0);

        // Drive the lifetime counter into saturation.
        en = 1'b1; tick();
        repeat (13) begin
            ce = 1'b1; repeat (4) tick();
            ce = 1'b0; tick();
            clr = 1'b1; len = 32'd0; tick();
            clr = 1'b0; tick();
        end
        ce = 1'b1; repeat (4) tick();
        check("t6_sat_cnt", 32'(cnt_o), CNT_MAX);
        check("t6_sat_pulse", 32'(pulse_o), 1);
        ce = 1'b0; tick();
        clr = 1'b1; tick();
        clr = 1'b0; tick();

        // Randomized traffic with bursty error activity.
        hot = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 16 == 0) hot = ($urandom_range(0, 1) == 1);
            en  = ($urandom_range(0, 15) != 0);
            ce  = hot ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            ie  = hot ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 5) == 0);
            len = 32'($urandom_range(0, 12));
            tick();
        end

        // Asynchronous reset in the middle of a cooldown.
        en = 1'b1; ce = 1'b0; ie = 1'b0; clr = 1'b0;
        repeat (60) tick();
        clr = 1'b1; len = 32'd0; tick();
        clr = 1'b0; repeat (2) tick();
        check("t6_pre_armed", 32'(state_o), 1);
        ce = 1'b1; repeat (4) tick();
        ce = 1'b0; tick();
        clr = 1'b1; len = 32'd50; tick();
        clr = 1'b0; repeat (5) tick();
        check("t6_mid_cooldown", 32'(state_o), 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_state", 32'(state_o), 0);
        check("t6_async_off", 32'(off_o), 0);
        check("t6_async_cnt", 32'(cnt_o), 0);
        check("t6_async_cause", 32'(cause_o), 0);
        check("t6_async_pulse", 32'(pulse_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_rearm", 32'(state_o), 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
